// File: rtl/interfaz_salida_param.sv
// ---------------------------------------------------------------------------
// interfaz_salida_param
//
// Output interface of an N-floor elevator car. It latches the button lamps
// until the car serves them and registers the floor number and travel
// direction for the displays. While the door is open, the floor display
// blinks.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   solicitud      one-cycle button pulses. The bit map is:
//                    [PISOS-1:0]           car buttons, floors 0..PISOS-1
//                    [2*PISOS-2:PISOS]     hall-up buttons, floors 0..PISOS-2
//                    [3*PISOS-3:2*PISOS-1] hall-down buttons, floors 1..PISOS-1
//   piso_actual    current car floor
//   subiendo       car moving up
//   bajando        car moving down
//   puerta_abierta door open at piso_actual
//   luces          latched lamp per button, using the same map as solicitud
//   display_num    floor shown on the display
//   display_dir    [0] activity (moving or any lamp lit), [1] travelling down
//   display_on     display enable, which blinks while the door is open
// ---------------------------------------------------------------------------
module interfaz_salida_param #(
  parameter int PISOS      = 4,
  parameter int ANCHO_PISO = 2,
  parameter int BLINK_DIV  = 4,
  parameter int N_BOT      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BOT-1:0]      solicitud,
  input  logic [ANCHO_PISO-1:0] piso_actual,
  input  logic                  subiendo,
  input  logic                  bajando,
  input  logic                  puerta_abierta,
  output logic [N_BOT-1:0]      luces,
  output logic [ANCHO_PISO-1:0] display_num,
  output logic [1:0]            display_dir,
  output logic                  display_on
);

  localparam int CW = $clog2(BLINK_DIV) + 1;
  localparam int PW = ANCHO_PISO + 1;
  localparam logic [CW-1:0] CNT_ULT = CW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PISOS_W = PW'(PISOS);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {REPOSO, MOVIENDO, PUERTA} estado_t;

  dir_t            dir_mem, dir_next;
  estado_t         estado, estado_next;
  logic [CW-1:0]   cnt;
  logic [N_BOT-1:0] servido, luces_next;
  logic            piso_ok, moviendo;

  // A floor code at or above PISOS is treated as invalid. When the code is
  // invalid, no lamp is served and the display keeps its last valid value.
  assign piso_ok  = {1'b0, piso_actual} < PISOS_W;
  assign moviendo = subiendo ^ bajando;

  // Build the mask of lamps served at the open door. The hall lamps obey the
  // remembered travel direction. Lamps that do not exist (up at the top
  // floor, down at floor 0) are never touched.
  always_comb begin
    servido = '0;
    if (puerta_abierta && piso_ok) begin
      for (int f = 0; f < PISOS; f++) begin
        if (piso_actual == ANCHO_PISO'(f)) begin
          servido[f] = 1'b1;
          if (f < PISOS - 1 && dir_mem != DIR_DOWN) servido[PISOS + f] = 1'b1;
          if (f > 0 && dir_mem != DIR_UP) servido[2*PISOS - 2 + f] = 1'b1;
        end
      end
    end
  end

  // Clearing a lamp wins over a new press of the same lamp. As a result, a
  // press at an open, servable door never lights its lamp.
  assign luces_next = (luces | solicitud) & ~servido;

  // Remember the last legal travel direction. Forget it only when the car
  // is fully idle: no lamps lit, not moving, and the door closed.
  always_comb begin
    dir_next = dir_mem;
    if (subiendo && !bajando)
      dir_next = DIR_UP;
    else if (bajando && !subiendo)
      dir_next = DIR_DOWN;
    else if (luces == '0 && !subiendo && !bajando && !puerta_abierta)
      dir_next = DIR_NONE;
  end

  // Indicator FSM. An open door takes priority over motion.
  always_comb begin
    estado_next = estado;
    if (puerta_abierta)
      estado_next = PUERTA;
    else begin
      case (estado)
        PUERTA:   estado_next = moviendo ? MOVIENDO : REPOSO;
        REPOSO:   estado_next = moviendo ? MOVIENDO : REPOSO;
        MOVIENDO: estado_next = (!subiendo && !bajando) ? REPOSO : MOVIENDO;
        default:  estado_next = REPOSO;
      endcase
    end
  end

  // Every output is registered here. The blink counter restarts each time
  // the door opens. This gives BLINK_DIV+1 edges from the door opening
  // until the first dark phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luces       <= '0;
      dir_mem     <= DIR_NONE;
      estado      <= REPOSO;
      cnt         <= '0;
      display_num <= '0;
      display_dir <= 2'b00;
      display_on  <= 1'b1;
    end else begin
      luces       <= luces_next;
      dir_mem     <= dir_next;
      estado      <= estado_next;
      display_dir <= {dir_next == DIR_DOWN, (|luces_next) | subiendo | bajando};
      if (piso_ok)
        display_num <= piso_actual;
      if (estado_next == PUERTA) begin
        if (estado != PUERTA) begin
          cnt        <= '0;
          display_on <= 1'b1;
        end else if (cnt == CNT_ULT) begin
          cnt        <= '0;
          display_on <= ~display_on;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt        <= '0;
        display_on <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interfaz_salida_param.sv
// ---------------------------------------------------------------------------
// tb_interfaz_salida_param
//
// Self-checking bench for interfaz_salida_param. The main instance has four
// floors. A second, three-floor instance exercises an out-of-range floor
// code. The reference model describes each button by its kind and floor,
// and derives the blink phase from the number of cycles the door has been
// open.
// ---------------------------------------------------------------------------
module tb_interfaz_salida_param;

  localparam int PISOS      = 4;
  localparam int ANCHO_PISO = 2;
  localparam int BLINK_DIV  = 4;
  localparam int N_BOT      = 10;
  localparam int D_NONE = 0, D_UP = 1, D_DN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_BOT-1:0]      solicitud = '0;
  logic [ANCHO_PISO-1:0] piso_actual = '0;
  logic subiendo = 1'b0, bajando = 1'b0, puerta_abierta = 1'b0;
  logic [N_BOT-1:0]      luces;
  logic [ANCHO_PISO-1:0] display_num;
  logic [1:0]            display_dir;
  logic                  display_on;

  logic [6:0] sol3 = '0;
  logic [1:0] piso3 = '0;
  logic sub3 = 1'b0, baj3 = 1'b0, door3 = 1'b0;
  logic [6:0] luces3;
  logic [1:0] num3;
  logic [1:0] dir3;
  logic       on3;

  int total = 0;
  int bad = 0;

  // Reference model state.
  logic [N_BOT-1:0]      m_luces;
  int                    m_dir;
  logic [ANCHO_PISO-1:0] m_num;
  logic [1:0]            m_ddir;
  logic                  m_on;
  int                    m_k;
  logic                  m_open;

  interfaz_salida_param #(.PISOS(PISOS), .ANCHO_PISO(ANCHO_PISO),
                          .BLINK_DIV(BLINK_DIV), .N_BOT(N_BOT)) dut (
    .clk(clk), .rst_n(rst_n), .solicitud(solicitud), .piso_actual(piso_actual),
    .subiendo(subiendo), .bajando(bajando), .puerta_abierta(puerta_abierta),
    .luces(luces), .display_num(display_num), .display_dir(display_dir),
    .display_on(display_on));

  interfaz_salida_param #(.PISOS(3), .ANCHO_PISO(2), .BLINK_DIV(BLINK_DIV),
                          .N_BOT(7)) dut3 (
    .clk(clk), .rst_n(rst_n), .solicitud(sol3), .piso_actual(piso3),
    .subiendo(sub3), .bajando(baj3), .puerta_abierta(door3),
    .luces(luces3), .display_num(num3), .display_dir(dir3),
    .display_on(on3));

  always #5 clk = ~clk;

  function automatic bit is_served(int idx, int piso, int dir);
    int kind, fl;
    if (idx < PISOS) begin kind = 0; fl = idx; end
    else if (idx < 2*PISOS-1) begin kind = 1; fl = idx - PISOS; end
    else begin kind = 2; fl = idx - (2*PISOS-2); end
    if (fl != piso) return 1'b0;
    if (kind == 0) return 1'b1;
    if (kind == 1) return dir != D_DN;
    return dir != D_UP;
  endfunction

  task automatic model_reset;
    m_luces = '0; m_dir = D_NONE; m_num = '0; m_ddir = 2'b00;
    m_on = 1'b1; m_k = 0; m_open = 1'b0;
  endtask

  task automatic model_edge;
    logic [N_BOT-1:0] nxt;
    int nd;
    nxt = m_luces | solicitud;
    if (puerta_abierta && int'(piso_actual) < PISOS)
      for (int i = 0; i < N_BOT; i++)
        if (is_served(i, int'(piso_actual), m_dir)) nxt[i] = 1'b0;
    nd = m_dir;
    if (subiendo && !bajando) nd = D_UP;
    else if (bajando && !subiendo) nd = D_DN;
    else if (m_luces == '0 && !subiendo && !bajando && !puerta_abierta) nd = D_NONE;
    m_ddir = {nd == D_DN, (nxt != '0) || subiendo || bajando};
    if (int'(piso_actual) < PISOS) m_num = piso_actual;
    if (puerta_abierta) begin
      if (!m_open) m_k = 0; else m_k++;
      m_on = ((m_k / BLINK_DIV) % 2) == 0;
    end else begin
      m_on = 1'b1;
    end
    m_open = puerta_abierta;
    m_luces = nxt;
    m_dir = nd;
  endtask

  task automatic step;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset;
    #12;
    total++; if (luces !== '0) begin bad++; $display("[TB] FAIL reset_luces got=%h exp=%h", luces, 10'h0); end
    total++; if (display_num !== 2'd0) begin bad++; $display("[TB] FAIL reset_num got=%h exp=0", display_num); end
    total++; if (display_dir !== 2'b00) begin bad++; $display("[TB] FAIL reset_dir got=%b exp=00", display_dir); end
    total++; if (display_on !== 1'b1) begin bad++; $display("[TB] FAIL reset_on got=%b exp=1", display_on); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_press_and_serve;
    solicitud = '0; solicitud[2] = 1'b1;
    step();
    solicitud = '0;
    total++; if (luces[2] !== 1'b1) begin bad++; $display("[TB] FAIL press_lamp got=%b exp=1", luces[2]); end
    total++; if (display_dir !== 2'b01) begin bad++; $display("[TB] FAIL press_dir got=%b exp=01", display_dir); end
    piso_actual = 2'd2; puerta_abierta = 1'b1;
    step();
    total++; if (luces[2] !== 1'b0) begin bad++; $display("[TB] FAIL serve_lamp got=%b exp=0", luces[2]); end
    total++; if (display_num !== 2'd2) begin bad++; $display("[TB] FAIL serve_num got=%h exp=2", display_num); end
    puerta_abierta = 1'b0;
    step(); step();
  endtask

  task automatic test_direction_clear;
    solicitud = '0; solicitud[5] = 1'b1; solicitud[7] = 1'b1;
    piso_actual = 2'd0;
    step();
    solicitud = '0; subiendo = 1'b1;
    step();
    piso_actual = 2'd1;
    step();
    subiendo = 1'b0; puerta_abierta = 1'b1;
    step();
    total++; if (luces[5] !== 1'b0) begin bad++; $display("[TB] FAIL dir_up_clear got=%b exp=0", luces[5]); end
    total++; if (luces[7] !== 1'b1) begin bad++; $display("[TB] FAIL dir_down_kept got=%b exp=1", luces[7]); end
    total++; if (display_dir !== 2'b01) begin bad++; $display("[TB] FAIL dir_display got=%b exp=01", display_dir); end
    total++; if (luces !== m_luces) begin bad++; $display("[TB] FAIL dir_luces got=%h exp=%h", luces, m_luces); end
    puerta_abierta = 1'b0; bajando = 1'b1;
    step();
    bajando = 1'b0; puerta_abierta = 1'b1;
    step();
    total++; if (luces !== 10'h000) begin bad++; $display("[TB] FAIL dir_down_clear got=%h exp=000", luces); end
    puerta_abierta = 1'b0;
    step(); step();
  endtask

  task automatic test_simultaneous;
    piso_actual = 2'd0; puerta_abierta = 1'b1;
    step();
    total++; if (display_dir !== 2'b00) begin bad++; $display("[TB] FAIL simul_idle_dir got=%b exp=00", display_dir); end
    solicitud = '0; solicitud[0] = 1'b1; solicitud[4] = 1'b1;
    step();
    solicitud = '0;
    total++; if (luces[0] !== 1'b0) begin bad++; $display("[TB] FAIL simul_car0 got=%b exp=0", luces[0]); end
    total++; if (luces[4] !== 1'b0) begin bad++; $display("[TB] FAIL simul_up0 got=%b exp=0", luces[4]); end
    puerta_abierta = 1'b0;
    step();
  endtask

  task automatic test_blink;
    logic exp_on;
    piso_actual = 2'd3; puerta_abierta = 1'b1;
    total++; if (display_on !== 1'b1) begin bad++; $display("[TB] FAIL blink_pre got=%b exp=1", display_on); end
    for (int i = 0; i < 20; i++) begin
      step();
      exp_on = ((i / BLINK_DIV) % 2) == 0;
      total++;
      if (display_on !== exp_on) begin
        bad++; $display("[TB] FAIL blink_cycle%0d got=%b exp=%b", i, display_on, exp_on);
      end
    end
    puerta_abierta = 1'b0;
    step();
    total++; if (display_on !== 1'b1) begin bad++; $display("[TB] FAIL blink_drop got=%b exp=1", display_on); end
  endtask

  task automatic test_boundary;
    bajando = 1'b1;
    step();
    total++; if (display_dir[1] !== 1'b1) begin bad++; $display("[TB] FAIL bnd_down got=%b exp=1", display_dir[1]); end
    subiendo = 1'b1;
    step(); step();
    total++; if (display_dir[1] !== 1'b1) begin bad++; $display("[TB] FAIL bnd_both_hold_dn got=%b exp=1", display_dir[1]); end
    bajando = 1'b0;
    step();
    bajando = 1'b1;
    step();
    total++; if (display_dir[1] !== 1'b0) begin bad++; $display("[TB] FAIL bnd_both_hold_up got=%b exp=0", display_dir[1]); end
    subiendo = 1'b0; bajando = 1'b0;
    step();
    // Three-floor instance: floor code 3 is out of range.
    sol3 = 7'h07; piso3 = 2'd2;
    step();
    sol3 = '0; piso3 = 2'd3; door3 = 1'b1;
    step(); step();
    total++; if (num3 !== 2'd2) begin bad++; $display("[TB] FAIL bnd_num_hold got=%h exp=2", num3); end
    total++; if (luces3 !== 7'h07) begin bad++; $display("[TB] FAIL bnd_no_clear got=%h exp=07", luces3); end
    door3 = 1'b0;
    step();
  endtask

  task automatic test_random;
    int r;
    for (int c = 0; c < 400; c++) begin
      solicitud = '0;
      if ($urandom_range(0, 2) == 0) solicitud[$urandom_range(0, N_BOT-1)] = 1'b1;
      if ($urandom_range(0, 5) == 0) solicitud[$urandom_range(0, N_BOT-1)] = 1'b1;
      if ($urandom_range(0, 4) == 0) piso_actual = 2'($urandom_range(0, PISOS-1));
      r = int'($urandom_range(0, 9));
      subiendo = (r == 6 || r == 7 || r == 9);
      bajando  = (r == 8 || r == 9);
      if ($urandom_range(0, 7) == 0) puerta_abierta = ~puerta_abierta;
      step();
      total++; if (luces !== m_luces) begin bad++; $display("[TB] FAIL rnd_luces c=%0d got=%h exp=%h", c, luces, m_luces); end
      total++; if (display_num !== m_num) begin bad++; $display("[TB] FAIL rnd_num c=%0d got=%h exp=%h", c, display_num, m_num); end
      total++; if (display_dir !== m_ddir) begin bad++; $display("[TB] FAIL rnd_dir c=%0d got=%b exp=%b", c, display_dir, m_ddir); end
      total++; if (display_on !== m_on) begin bad++; $display("[TB] FAIL rnd_on c=%0d got=%b exp=%b", c, display_on, m_on); end
    end
    solicitud = '0; subiendo = 1'b0; bajando = 1'b0; puerta_abierta = 1'b0;
    step();
  endtask

  task automatic test_reset_midblink;
    solicitud = '1; piso_actual = 2'd0; puerta_abierta = 1'b0;
    step();
    solicitud = '0;
    total++; if (luces !== 10'h3FF) begin bad++; $display("[TB] FAIL mid_all_lit got=%h exp=3ff", luces); end
    piso_actual = 2'd3; puerta_abierta = 1'b1;
    for (int i = 0; i < 6; i++) step();
    total++; if (display_on !== 1'b0) begin bad++; $display("[TB] FAIL mid_dark got=%b exp=0", display_on); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (luces !== 10'h000) begin bad++; $display("[TB] FAIL mid_rst_luces got=%h exp=000", luces); end
    total++; if (display_on !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_on got=%b exp=1", display_on); end
    total++; if (display_dir !== 2'b00) begin bad++; $display("[TB] FAIL mid_rst_dir got=%b exp=00", display_dir); end
    total++; if (display_num !== 2'd0) begin bad++; $display("[TB] FAIL mid_rst_num got=%h exp=0", display_num); end
    puerta_abierta = 1'b0; piso_actual = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_and_serve();
    test_direction_clear();
    test_simultaneous();
    test_blink();
    test_boundary();
    test_random();
    test_reset_midblink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
